inst_fetch_unit: RTL

//  IF stage of the pipelined MIPS CPU and the initiator side of the instruction-ROM interface.

---
 rtl/inst_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// IF stage of the pipelined MIPS CPU: PC register, instruction-ROM initiator and IF/ID register.
// Optional fetch trap on the unmapped-ROM word is enabled by defining FETCH_TRAP_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        trap,
  output logic [31:0] epc
);

  localparam logic [31:0] UNMAPPED_WORD = 32'h8000_0000;

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] pc_plus4_nxt;
  logic        vld_nxt;
  logic [31:0] count_nxt;
  logic        trap_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  assign rom_addr = {pc[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_TRAP_EN
  assign trap_hit = (rom_data == UNMAPPED_WORD) && !stall && !flush && !redirect_valid;
`else
  assign trap_hit = 1'b0;
`endif

  // Next-state: PC selection and IF/ID load/hold/bubble decision
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    inst_nxt     = if_id_inst;
    pc_plus4_nxt = if_id_pc_plus4;
    vld_nxt      = if_id_valid;
    count_nxt    = fetch_count;

    case (state)
      ST_RESET: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase

    if (redirect_valid)
      pc_nxt = {redirect_pc[31:2], 2'b00};
    else if (trap_hit)
      pc_nxt = EXC_PC;
    else if (!stall)
      pc_nxt = pc_plus4;

    if (flush || redirect_valid || trap_hit) begin
      inst_nxt     = 32'h0;
      pc_plus4_nxt = 32'h0;
      vld_nxt      = 1'b0;
    end else if (!stall) begin
      inst_nxt     = rom_data;
      pc_plus4_nxt = pc_plus4;
      vld_nxt      = 1'b1;
      count_nxt    = sat_inc(fetch_count);
    end
  end

  // Registered PC, IF/ID register and delivered-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_RESET;
      pc             <= RESET_PC;
      if_id_inst     <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_inst     <= inst_nxt;
      if_id_pc_plus4 <= pc_plus4_nxt;
      if_id_valid    <= vld_nxt;
      fetch_count    <= count_nxt;
    end
  end

`ifdef FETCH_TRAP_EN
  // Trap pulse and sticky exception PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap <= 1'b0;
      epc  <= 32'h0;
    end else begin
      trap <= trap_hit;
      if (trap_hit)
        epc <= pc;
    end
  end
`else
  assign trap = 1'b0;
  assign epc  = 32'h0;
`endif

endmodule
